// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester command/response and APB bus bundle for apb_req_arbiter.
// The pready signal exists only when APB_PREADY_EN is defined.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, pwdata, prdata;
  logic [ADDR_W-1:0]         paddr;
  logic                      psel, penable, pwrite, busy;
`ifdef APB_PREADY_EN
  logic                      pready;
`endif
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
`ifdef APB_PREADY_EN
    input  pready,
`endif
    output req_ready, rsp_valid, rsp_rdata, psel, penable, pwrite, paddr, pwdata, busy
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
`ifdef APB_PREADY_EN
    output pready,
`endif
    input  req_ready, rsp_valid, rsp_rdata, psel, penable, pwrite, paddr, pwdata, busy
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master sharing one bus among NUM_REQ requesters.
// Define APB_PREADY_EN to honour pready wait states; otherwise ACCESS lasts exactly one cycle.
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                pclk_i,
  input  logic                presetn_i,
  apb_req_arbiter_if.master   bus
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int IW1 = IW + 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d, gnt_q, gnt_d, win;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rsp_q, rsp_d;
  logic                done, take;

`ifdef APB_PREADY_EN
  assign done = (state_q == ACCESS) && bus.pready;
`else
  assign done = state_q == ACCESS;
`endif
  assign take = (state_q == IDLE || done) && |bus.req_valid;

  // Scan from rr_q downwards in reverse so the closest valid requester wins last
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IW:0] idx;
      idx = IW1'(rr_q) + IW1'(k);
      if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
      if (bus.req_valid[idx[IW-1:0]]) win = idx[IW-1:0];
    end
  end

  always_comb begin
    state_d  = take ? SETUP : (state_q == SETUP || (state_q == ACCESS && !done)) ? ACCESS : IDLE;
    rr_d     = take ? ((win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1)) : rr_q;
    gnt_d    = take ? win : gnt_q;
    pwrite_d = take ? bus.req_write[win] : pwrite_q;
    paddr_d  = take ? bus.req_addr[win*ADDR_W +: ADDR_W] : paddr_q;
    pwdata_d = take ? bus.req_wdata[win*DATA_W +: DATA_W] : pwdata_q;
    rsp_d    = done ? ONE << gnt_q : '0;
    rdata_d  = (done && !pwrite_q) ? bus.prdata : '0;
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rsp_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rsp_q    <= rsp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Ready is combinational, so it must be masked while reset holds the FSM
  assign bus.req_ready = (take && presetn_i) ? ONE << win : '0;
  assign bus.psel      = state_q != IDLE;
  assign bus.penable   = state_q == ACCESS;
  assign bus.busy      = state_q != IDLE;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
endmodule
